hash_arbiter: RTL and testbench

Shares one `full_hash` core among `NUM_REQ` byte-stream requesters. Requesters are granted round-robin, and a grant is held for one whole message: start, bytes, End_of_File, result. The block muxes each requester's handshake onto the core and returns the 32-bit digest tagged with the requester id. A watchdog aborts and resets the core when the granted stream stalls.

---
 rtl/hash_arb_pkg.sv | 16 +
 rtl/hash_arbiter_rr.sv | 31 +++
 rtl/hash_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_hash_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_arb_pkg.sv
// Shared types and widths for the hash core arbiter.
// state_t: arbiter FSM; BYTE_W/HASH_W: stream and digest widths.
package hash_arb_pkg;

  localparam int BYTE_W = 8;
  localparam int HASH_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_HASH,
    ABORT
  } state_t;

endpackage

// File: rtl/hash_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i.
// req_i/ptr_i in; gnt_o one-hot, id_o encoded winner, any_o request seen.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] id_o,
  output logic                 any_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// Shares one hash core among NUM_REQ byte-stream requesters, one message per grant.
// req_* per-requester handshakes, res_* tagged digest/abort, core_* core-side bus.
module hash_arbiter
  import hash_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int RST_CYC = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_start,
  input  logic [BYTE_W*NUM_REQ-1:0]   req_byte,
  input  logic [NUM_REQ-1:0]          req_dr,
  input  logic [NUM_REQ-1:0]          req_eof,
  output logic [NUM_REQ-1:0]          req_rtr,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [HASH_W-1:0]           res_hash,
  output logic [$clog2(NUM_REQ)-1:0]  res_id,
  output logic                        res_valid,
  output logic                        res_err,
  output logic                        core_rst_n,
  output logic                        core_start,
  output logic [BYTE_W-1:0]           core_byte,
  output logic                        core_eof,
  output logic                        core_dr,
  input  logic                        core_rtr,
  input  logic                        core_h_ready,
  input  logic [0:HASH_W-1]           core_r_h
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT > RST_CYC) ? TIMEOUT : RST_CYC;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] RC_LAST = CW'(RST_CYC - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  goh_q, goh_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HASH_W-1:0]   hash_q, hash_d;
  logic [IW-1:0]       rid_q, rid_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
  logic                crn_q, crn_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IW-1:0]       arb_id;
  logic                arb_any;
  logic [IW-1:0]       nxt_ptr;
  logic                strm;
  logic                owned;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_start),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .id_o  (arb_id),
    .any_o (arb_any)
  );

  assign strm  = (state_q == STREAM);
  assign owned = (state_q == START) || strm ||
                 (state_q == WAIT_HASH);

  assign nxt_ptr = (gnt_q == IW'(NUM_REQ - 1)) ?
                   '0 : gnt_q + IW'(1);

  assign core_start = (state_q == START);
  assign core_byte  = strm ?
                      req_byte[gnt_q*BYTE_W +: BYTE_W] : '0;
  assign core_dr    = strm && req_dr[gnt_q];
  assign core_eof   = strm && req_eof[gnt_q];
  assign req_rtr    = (strm && core_rtr) ? goh_q : '0;
  assign req_grant  = owned ? goh_q : '0;
  assign core_rst_n = crn_q;
  assign res_hash   = hash_q;
  assign res_id     = rid_q;
  assign res_valid  = vld_q;
  assign res_err    = err_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    goh_d   = goh_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hash_d  = hash_q;
    rid_d   = rid_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_id;
          goh_d   = arb_gnt;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        // EOF acceptance outranks a same-cycle timeout
        if (req_eof[gnt_q] && core_rtr) begin
          cnt_d   = '0;
          state_d = WAIT_HASH;
        end else if (core_dr && core_rtr) begin
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          rid_d   = gnt_q;
          ptr_d   = nxt_ptr;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_HASH: begin
        if (core_h_ready) begin
          // core bus is MSB-first: core_r_h[k] -> res_hash[31-k]
          hash_d  = core_r_h;
          rid_d   = gnt_q;
          vld_d   = 1'b1;
          ptr_d   = nxt_ptr;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          rid_d   = gnt_q;
          ptr_d   = nxt_ptr;
          state_d = ABORT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        if (cnt_q == RC_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // core held in reset for exactly the ABORT residency
    crn_d = (state_d != ABORT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      goh_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hash_q  <= '0;
      rid_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      crn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      goh_q   <= goh_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      rid_q   <= rid_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      crn_q   <= crn_d;
    end
  end

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter with a behavioural FNV-1a core model.
// Expected digests go to a scoreboard queue and are matched as results appear.
module tb_hash_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int RC = 4;
  localparam logic [31:0] SEED  = 32'h811C9DC5;
  localparam logic [31:0] PRIME = 32'h01000193;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] h;
  } res_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_start = '0;
  logic [8*N-1:0] req_byte = '0;
  logic [N-1:0]   req_dr = '0;
  logic [N-1:0]   req_eof = '0;
  logic [N-1:0]   req_rtr;
  logic [N-1:0]   req_grant;
  logic [31:0]    res_hash;
  logic [1:0]     res_id;
  logic           res_valid;
  logic           res_err;
  logic           core_rst_n;
  logic           core_start;
  logic [7:0]     core_byte;
  logic           core_eof;
  logic           core_dr;
  logic           core_rtr;
  logic           core_h_ready = 1'b0;
  logic [0:31]    core_r_h = '0;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, n_cs = 0, n_valid = 0, n_err = 0, n_crl = 0;
  int g_cyc = 0, err_cyc = 0, acc_cyc = 0;
  logic [1:0] err_id = '0;
  logic [1:0] g_log[$];
  res_t got_q[$];
  res_t sb[$];

  logic [55:0] outs;
  assign outs = {req_rtr, req_grant, res_hash, res_id,
                 res_valid, res_err, core_rst_n, core_start,
                 core_byte, core_eof, core_dr};

  hash_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO),
    .RST_CYC (RC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_start    (req_start),
    .req_byte     (req_byte),
    .req_dr       (req_dr),
    .req_eof      (req_eof),
    .req_rtr      (req_rtr),
    .req_grant    (req_grant),
    .res_hash     (res_hash),
    .res_id       (res_id),
    .res_valid    (res_valid),
    .res_err      (res_err),
    .core_rst_n   (core_rst_n),
    .core_start   (core_start),
    .core_byte    (core_byte),
    .core_eof     (core_eof),
    .core_dr      (core_dr),
    .core_rtr     (core_rtr),
    .core_h_ready (core_h_ready),
    .core_r_h     (core_r_h)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] step(input logic [31:0] h,
                                       input logic [7:0] b);
    return (h ^ {24'h0, b}) * PRIME;
  endfunction

  function automatic logic [31:0] digest(input string s);
    logic [31:0] h;
    h = SEED;
    for (int i = 0; i < s.len(); i++) h = step(h, s[i]);
    return h;
  endfunction

  function automatic logic [1:0] oh2id(input logic [3:0] g);
    logic [1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) if (g[i]) v = 2'(i);
    return v;
  endfunction

  function automatic logic [7:0] order4(input int b);
    logic [7:0] v;
    v = 8'hFF;
    for (int k = 0; k < 4; k++)
      if (b + k < g_log.size()) v[7-2*k -: 2] = g_log[b+k];
    return v;
  endfunction

  // behavioural core: ready while a message is open, digest 3 cycles after EOF
  logic busy = 1'b0;
  logic fin = 1'b0;
  logic [31:0] hacc = '0;
  int lat = 0;
  assign core_rtr = busy;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      busy <= 1'b0;
      fin <= 1'b0;
      core_h_ready <= 1'b0;
    end else begin
      core_h_ready <= 1'b0;
      if (core_start) begin
        busy <= 1'b1;
        fin <= 1'b0;
        hacc <= SEED;
      end else if (busy) begin
        if (core_dr) hacc <= step(hacc, core_byte);
        if (core_eof) begin
          busy <= 1'b0;
          fin <= 1'b1;
          lat <= 0;
        end
      end else if (fin) begin
        if (lat == 2) begin
          fin <= 1'b0;
          core_h_ready <= 1'b1;
          core_r_h <= hacc;
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (core_start) begin
      n_cs++;
      g_log.push_back(oh2id(req_grant));
      g_cyc = cyc;
    end
    if (res_valid) begin
      got_q.push_back({res_id, res_hash});
      n_valid++;
    end
    if (res_err) begin
      n_err++;
      err_cyc = cyc;
      err_id = res_id;
    end
    if (!core_rst_n && !rst) n_crl++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic grab(input int r);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!req_grant[r] && n < 400);
    req_start[r] = 1'b0;
    chk("grant_tmo", 64'(req_grant[r]), 64'd1);
  endtask

  task automatic send(input int r, input logic [7:0] b,
                      input logic eof);
    logic acc;
    int n;
    req_byte[8*r +: 8] = b;
    req_dr[r] = !eof;
    req_eof[r] = eof;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = req_rtr[r];
      @(posedge clk); #1;
      n++;
    end
    acc_cyc = cyc;
    req_dr[r] = 1'b0;
    req_eof[r] = 1'b0;
    chk("hs_tmo", 64'(acc), 64'd1);
  endtask

  task automatic wait_res();
    int n;
    res_t g, e;
    n = 0;
    while (got_q.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("res_tmo", 64'(got_q.size() != 0), 64'd1);
    if (got_q.size() != 0 && sb.size() != 0) begin
      g = got_q.pop_front();
      e = sb.pop_front();
      chk("res_id", 64'(g.id), 64'(e.id));
      chk("res_hash", 64'(g.h), 64'(e.h));
    end
  endtask

  task automatic serve(input int r, input string s, input int rp);
    int cs0;
    grab(r);
    sb.push_back({2'(r), digest(s)});
    cs0 = -1;
    for (int i = 0; i < s.len(); i++) begin
      send(r, s[i], 1'b0);
      if (i == 0) cs0 = n_cs;
      if (i == rp) begin
        req_start[r] = 1'b1;
        @(posedge clk); #1;
        req_start[r] = 1'b0;
      end
    end
    send(r, 8'h00, 1'b1);
    if (cs0 < 0) cs0 = n_cs;
    wait_res();
    chk("no_restart", 64'(n_cs), 64'(cs0));
  endtask

  initial begin
    int g0, v0, e0, l0, a, n;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 64'(outs), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", 64'(core_rst_n), 64'd1);
    @(posedge clk); #1;

    // all four request at once, pointer at 0
    g0 = g_log.size();
    req_start = 4'b1111;
    serve(0, "alpha", -1);
    serve(1, "bravo!", -1);
    serve(2, "charlie", -1);
    serve(3, "dx", -1);
    chk("order_0123", 64'(order4(g0)), 64'h1B);

    // single requester 0
    v0 = n_valid;
    req_start[0] = 1'b1;
    serve(0, "CiaoMondo", -1);
    repeat (8) @(posedge clk);
    #1;
    chk("one_valid", 64'(n_valid - v0), 64'd1);

    // requester 1 re-pulses start mid-message
    req_start[1] = 1'b1;
    serve(1, "CiaoMondo", 2);

    // pointer now 2
    g0 = g_log.size();
    req_start = 4'b1111;
    serve(2, "echo", -1);
    serve(3, "foxtrot", -1);
    serve(0, "golf", -1);
    serve(1, "hotel", -1);
    chk("order_2301", 64'(order4(g0)), 64'hB1);

    // grant latency and empty message
    req_start[2] = 1'b1;
    @(negedge clk);
    chk("gnt_early", 64'(req_grant), 64'd0);
    @(negedge clk);
    chk("gnt_lat", 64'({req_grant, core_start}), 64'b0100_1);
    serve(2, "", -1);

    // watchdog abort on stalled requester 3, requester 0 waiting
    e0 = n_err;
    l0 = n_crl;
    req_start = 4'b1001;
    grab(3);
    send(3, 8'h43, 1'b0);
    send(3, 8'h69, 1'b0);
    a = acc_cyc;
    n = 0;
    while (n_err == e0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("err_seen", 64'(n_err - e0), 64'd1);
    chk("err_lat", 64'(err_cyc - a), 64'(TO));
    chk("err_id", 64'(err_id), 64'd3);
    serve(0, "Hola", -1);
    chk("regrant_lat", 64'(g_cyc - err_cyc), 64'(RC + 1));
    chk("crst_low", 64'(n_crl - l0), 64'(RC));

    // reset mid-stream, then replay
    req_start[1] = 1'b1;
    grab(1);
    send(1, 8'h43, 1'b0);
    send(1, 8'h69, 1'b0);
    send(1, 8'h61, 1'b0);
    send(1, 8'h6F, 1'b0);
    v0 = n_valid;
    e0 = n_err;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold", 64'(outs), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_crst", 64'(core_rst_n), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_res", 64'({n_valid - v0, n_err - e0}), 64'd0);
    req_start[1] = 1'b1;
    serve(1, "CiaoMondo", -1);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_drain", 64'(sb.size() + got_q.size()), 64'd0);
    chk("err_total", 64'(n_err), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
